// File: rtl/gpio_in_debounce.sv
// GPIO input conditioner: per-bit synchroniser and debouncer feeding GPIO_IN,
// with sticky rise/fall event flags and a maskable level interrupt.
module gpio_in_debounce #(
  parameter int unsigned            WIDTH           = 8,
  parameter int unsigned            SYNC_STAGES     = 2,
  parameter int unsigned            DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]       INIT_LEVEL      = '0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise_flag,
  output logic [WIDTH-1:0] fall_flag,
  input  logic [WIDTH-1:0] flag_clr,
  input  logic [WIDTH-1:0] irq_en,
  output logic             irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Plain flop chain: stage 0 takes the raw pin, the last stage is "sync".
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT_LEVEL;
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_ev;
  logic [WIDTH-1:0] fall_ev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic             differ;

    assign differ    = sync[i] ^ gpio_in[i];
    assign accept[i] = differ && (cnt_q == CNT_MAX);
    assign rise_ev[i] = accept[i] &  sync[i];
    assign fall_ev[i] = accept[i] & ~sync[i];

    // Any return to the stable level restarts the count, so the counter
    // is bounded by CNT_MAX and short pulses never get through.
    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        cnt_q      <= '0;
        gpio_in[i] <= INIT_LEVEL[i];
      end else if (!differ) begin
        cnt_q <= '0;
      end else if (accept[i]) begin
        cnt_q      <= '0;
        gpio_in[i] <= sync[i];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // A new event beats a same-cycle clear; the clear still removes the
    // opposite-direction flag.
    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        rise_flag[i] <= 1'b0;
        fall_flag[i] <= 1'b0;
      end else begin
        rise_flag[i] <= rise_ev[i] | (rise_flag[i] & ~flag_clr[i]);
        fall_flag[i] <= fall_ev[i] | (fall_flag[i] & ~flag_clr[i]);
      end
    end
  end

  assign irq = |((rise_flag | fall_flag) & irq_en);

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with default parameters
// (8 bits, 2 sync stages, 16-cycle debounce => 18-edge latency).
module tb_gpio_in_debounce;

  localparam int WIDTH = 8;

  logic             HCLK;
  logic             HRESET;
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] rise_flag;
  logic [WIDTH-1:0] fall_flag;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] irq_en;
  logic             irq;

  int n_total = 0;
  int n_bad   = 0;

  gpio_in_debounce #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .INIT_LEVEL(8'h00)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .pin_in(pin_in), .gpio_in(gpio_in),
    .rise_flag(rise_flag), .fall_flag(fall_flag), .flag_clr(flag_clr),
    .irq_en(irq_en), .irq(irq)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at negedges; each tick crosses one posedge.
  task automatic tick(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] g, input logic [7:0] r, input logic [7:0] f);
    check_val({tag, "_gpio"}, 32'(gpio_in), 32'(g));
    check_val({tag, "_rise"}, 32'(rise_flag), 32'(r));
    check_val({tag, "_fall"}, 32'(fall_flag), 32'(f));
  endtask

  initial begin
    HRESET   = 1'b1;
    pin_in   = '0;
    flag_clr = '0;
    irq_en   = '0;
    tick(3);
    check_outs("reset", 8'h00, 8'h00, 8'h00);
    check_val("reset_irq", 32'(irq), 32'd0);
    HRESET = 1'b0;
    tick(2);

    // Bit 0 rise: nothing at edge 17, accepted at edge 18.
    pin_in = 8'h01;
    tick(17);
    check_outs("b0_e17", 8'h00, 8'h00, 8'h00);
    tick(1);
    check_outs("b0_e18", 8'h01, 8'h01, 8'h00);

    // Interrupt masking and write-1-to-clear.
    irq_en = 8'h01;
    #1 check_val("irq_en_on", 32'(irq), 32'd1);
    irq_en = 8'h00;
    #1 check_val("irq_masked", 32'(irq), 32'd0);
    check_val("flag_kept", 32'(rise_flag), 32'h01);
    irq_en = 8'h01;
    tick(1);
    flag_clr = 8'h01;
    tick(1);
    flag_clr = 8'h00;
    check_val("clr_rise", 32'(rise_flag), 32'h00);
    check_val("clr_irq", 32'(irq), 32'd0);

    // Bit 3: 15-cycle pulse rejected.
    pin_in = 8'h09;
    tick(15);
    pin_in = 8'h01;
    tick(30);
    check_outs("p15", 8'h01, 8'h00, 8'h00);

    // Bit 3: 16-cycle pulse accepted, then released 16 cycles later.
    pin_in = 8'h09;
    tick(16);
    pin_in = 8'h01;
    tick(2);
    check_outs("p16_hi", 8'h09, 8'h08, 8'h00);
    tick(15);
    check_val("p16_still_hi", 32'(gpio_in), 32'h09);
    tick(1);
    check_outs("p16_lo", 8'h01, 8'h08, 8'h08);
    flag_clr = 8'h08;
    tick(1);
    flag_clr = 8'h00;
    check_outs("p16_clr", 8'h01, 8'h00, 8'h00);

    // Bit 5 bounce: 3-cycle toggles for 42 cycles, then held high.
    for (int i = 0; i < 14; i++) begin
      pin_in[5] = (i % 2 == 0);
      tick(3);
    end
    check_outs("bounce", 8'h01, 8'h00, 8'h00);
    pin_in[5] = 1'b1;
    tick(17);
    check_outs("bounce_e17", 8'h01, 8'h00, 8'h00);
    tick(1);
    check_outs("bounce_e18", 8'h21, 8'h20, 8'h00);

    // Events coinciding with clears: bit 2 rises, bit 5 falls, both cleared that edge.
    pin_in = 8'h05;
    tick(17);
    flag_clr = 8'h24;
    tick(1);
    flag_clr = 8'h00;
    check_outs("coincide", 8'h05, 8'h04, 8'h20);

    // Asynchronous reset mid-cycle, pins held 0xFF through release.
    irq_en = 8'hFF;
    pin_in = 8'hFF;
    #1 check_val("pre_rst_irq", 32'(irq), 32'd1);
    #1 HRESET = 1'b1;
    #1;
    check_outs("async_rst", 8'h00, 8'h00, 8'h00);
    check_val("async_rst_irq", 32'(irq), 32'd0);
    tick(2);
    HRESET = 1'b0;
    tick(17);
    check_outs("ff_e17", 8'h00, 8'h00, 8'h00);
    tick(1);
    check_outs("ff_e18", 8'hFF, 8'hFF, 8'h00);
    check_val("ff_irq", 32'(irq), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
